store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/mem_pkg.sv | 12 +
 rtl/sb_match.sv | 36 +++
 rtl/store_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: default widths and the store-buffer FSM encoding.
package mem_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_IDX_W  = 12;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_match.sv
// Youngest-match lookup over the store-buffer entries.
// Entries are scanned oldest to youngest, so the last hit seen is the youngest.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 12,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       valid,
  input  logic [DEPTH*IDX_W-1:0] addr_vec,
  input  logic [PTR_W-1:0]       head,
  input  logic [IDX_W-1:0]       ld_addr,
  output logic                   hit,
  output logic [PTR_W-1:0]       idx
);

  logic [DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = valid[gi] && (addr_vec[gi*IDX_W +: IDX_W] == ld_addr);
    end
  endgenerate

  // Walk from head (oldest) upward; a later match overrides an earlier one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (match[head + PTR_W'(a)]) begin
        hit = 1'b1;
        idx = head + PTR_W'(a);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core and a single-port data memory.
// Stores queue in a FIFO and drain whenever the memory port is free;
// loads forward from the youngest matching entry or read memory directly.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = MEM_DATA_W,
  parameter int IDX_W  = MEM_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              flush_done,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  sb_state_e        state_reg, state_next;
  logic             flush_done_reg, flush_done_next;

  logic [DEPTH-1:0]       valid_vec;
  logic [DEPTH*IDX_W-1:0] idx_vec;
  logic                   hit;
  logic [PTR_W-1:0]       hit_idx;
  logic                   load_miss, do_drain, do_enq;

  // An entry is live when its distance from head is below the fill count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      assign age = PTR_W'(gi) - head_reg;
      assign valid_vec[gi] = ({1'b0, age} < count_reg);
      assign idx_vec[gi*IDX_W +: IDX_W] = addr_mem[gi][IDX_W-1:0];
    end
  endgenerate

  sb_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .PTR_W (PTR_W)
  ) u_match (
    .valid    (valid_vec),
    .addr_vec (idx_vec),
    .head     (head_reg),
    .ld_addr  (cpu_addr[IDX_W-1:0]),
    .hit      (hit),
    .idx      (hit_idx)
  );

  assign empty      = (count_reg == '0);
  assign flush_done = flush_done_reg;

  // Port arbitration, load forwarding, enqueue/drain decisions and next state.
  always_comb begin
    state_next      = state_reg;
    flush_done_next = 1'b0;
    cpu_rdata       = '0;
    cpu_stall       = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    load_miss       = 1'b0;
    do_drain        = 1'b0;
    do_enq          = 1'b0;

    if (state_reg == RUN) begin
      // A store takes priority; a simultaneous load is ignored.
      if (cpu_re && !cpu_we) begin
        if (hit) begin
          cpu_rdata = data_mem[hit_idx];
        end else begin
          load_miss = 1'b1;
          mem_re    = 1'b1;
          mem_addr  = cpu_addr;
          cpu_rdata = mem_rdata;
        end
      end
      do_drain  = rst_n && (count_reg != '0) && !load_miss;
      do_enq    = rst_n && cpu_we && ((count_reg != FULL_CNT) || do_drain);
      cpu_stall = cpu_we && !do_enq;
    end else begin
      cpu_stall = cpu_we || cpu_re;
      do_drain  = rst_n && (count_reg != '0);
    end

    // A reset cycle never writes memory, so held entries are simply lost.
    if (do_drain) begin
      mem_we    = 1'b1;
      mem_addr  = addr_mem[head_reg];
      mem_wdata = data_mem[head_reg];
    end

    head_next  = do_drain ? head_reg + PTR_W'(1) : head_reg;
    tail_next  = do_enq   ? tail_reg + PTR_W'(1) : tail_reg;
    count_next = count_reg;
    if (do_enq && !do_drain) count_next = count_reg + CNT_W'(1);
    if (!do_enq && do_drain) count_next = count_reg - CNT_W'(1);

    // A flush that empties the buffer in its own cycle completes immediately.
    if (state_reg == RUN) begin
      if (flush) begin
        if (count_next == '0) flush_done_next = 1'b1;
        else                  state_next      = FLUSH;
      end
    end else if (count_next == '0) begin
      state_next      = RUN;
      flush_done_next = 1'b1;
    end
  end

  // Control state: pointers, count, FSM and the flush-done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      state_reg      <= RUN;
      flush_done_reg <= 1'b0;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      state_reg      <= state_next;
      flush_done_reg <= flush_done_next;
    end
  end

  // Entry storage; contents are don't-care until enqueued.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_mem[tail_reg] <= cpu_addr;
      data_mem[tail_reg] <= cpu_wdata;
    end
  end

endmodule
